// File: rtl/axis_deheaderizer_pkg.sv
// Shared header format and FSM encoding for the AXIS deheaderizer/headerizer pair.
// Field offsets are derived from the sidechannel widths so both ends agree on the layout.
package axis_deheaderizer_pkg;

    typedef enum logic [0:0] {
        WAIT_HDR = 1'b0,
        PASS     = 1'b1
    } dehdr_state_e;

    localparam int USER_LSB = 0;

    function automatic int hdr_id_lsb(input int user_width);
        return USER_LSB + user_width;
    endfunction

    function automatic int hdr_dest_lsb(input int user_width, input int id_width);
        return hdr_id_lsb(user_width) + id_width;
    endfunction

    function automatic int hdr_last_bit(input int user_width, input int id_width, input int dest_width);
        return hdr_dest_lsb(user_width, id_width) + dest_width;
    endfunction

    function automatic int hdr_pad_lsb(input int user_width, input int id_width, input int dest_width);
        return hdr_last_bit(user_width, id_width, dest_width) + 1;
    endfunction

endpackage

// File: rtl/axis_deheaderizer_if.sv
// Bundled header-prefixed input stream and restored payload stream.
// slave = view of the deheaderizer itself, master = view of the surrounding environment.
interface axis_deheaderizer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 16,
    parameter int ID_WIDTH   = 16,
    parameter int USER_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]   hdr_TDATA;
    logic [DATA_WIDTH/8-1:0] hdr_TKEEP;
    logic                    hdr_TLAST;
    logic                    hdr_TVALID;
    logic                    hdr_TREADY;

    logic [DATA_WIDTH-1:0]   sides_TDATA;
    logic [DATA_WIDTH/8-1:0] sides_TKEEP;
    logic                    sides_TLAST;
    logic                    sides_TVALID;
    logic                    sides_TREADY;
    logic [DEST_WIDTH-1:0]   sides_TDEST;
    logic [ID_WIDTH-1:0]     sides_TID;
    logic [USER_WIDTH-1:0]   sides_TUSER;

    modport slave (
        input  hdr_TDATA, hdr_TKEEP, hdr_TLAST, hdr_TVALID, sides_TREADY,
        output hdr_TREADY, sides_TDATA, sides_TKEEP, sides_TLAST, sides_TVALID,
               sides_TDEST, sides_TID, sides_TUSER
    );

    modport master (
        output hdr_TDATA, hdr_TKEEP, hdr_TLAST, hdr_TVALID, sides_TREADY,
        input  hdr_TREADY, sides_TDATA, sides_TKEEP, sides_TLAST, sides_TVALID,
               sides_TDEST, sides_TID, sides_TUSER
    );
endinterface

// File: rtl/axis_deheaderizer_skid_reg.sv
// Two-entry (main + skid) output register: one cycle latency, full throughput,
// in_ready is a pure register so there is no combinational path from out_ready.
module axis_skid_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [WIDTH-1:0] main_data_r;
    logic [WIDTH-1:0] skid_data_r;
    logic             main_valid_r;
    logic             skid_valid_r;

    assign in_ready  = ~skid_valid_r;
    assign out_data  = main_data_r;
    assign out_valid = main_valid_r;

    // Main/skid entry update; the skid only fills when main is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_data_r  <= '0;
            skid_data_r  <= '0;
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (skid_valid_r) begin
            if (out_ready) begin
                main_data_r  <= skid_data_r;
                skid_valid_r <= 1'b0;
            end
        end else if (in_valid) begin
            if (!main_valid_r || out_ready) begin
                main_data_r  <= in_data;
                main_valid_r <= 1'b1;
            end else begin
                skid_data_r  <= in_data;
                skid_valid_r <= 1'b1;
            end
        end else if (out_ready) begin
            main_valid_r <= 1'b0;
        end
    end
endmodule

// File: rtl/axis_deheaderizer.sv
// Strips a one-flit header carrying DEST/ID/USER and restores them as sidechannels.
// Optional protocol checker enabled by AXIS_DEHEADERIZER_CHECK_EN adds a sticky err output.
module axis_deheaderizer
    import axis_deheaderizer_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 16,
    parameter int ID_WIDTH   = 16,
    parameter int USER_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    axis_deheaderizer_if.slave bus
`ifdef AXIS_DEHEADERIZER_CHECK_EN
    ,
    output logic              err
`endif
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int ID_LSB     = hdr_id_lsb(USER_WIDTH);
    localparam int DEST_LSB   = hdr_dest_lsb(USER_WIDTH, ID_WIDTH);
    localparam int PAY_WIDTH  = DATA_WIDTH + KEEP_WIDTH + 1 + DEST_WIDTH + ID_WIDTH + USER_WIDTH;

    dehdr_state_e          state_r;
    dehdr_state_e          state_nxt_s;
    logic                  ready_en_r;
    logic [DEST_WIDTH-1:0] dest_r;
    logic [ID_WIDTH-1:0]   id_r;
    logic [USER_WIDTH-1:0] user_r;
    logic                  hdr_ready_s;
    logic                  hdr_fire_s;
    logic                  skid_in_valid_s;
    logic                  skid_in_ready_s;
    logic                  pass_fire_s;
    logic [PAY_WIDTH-1:0]  skid_out_s;

    // State register; ready_en_r keeps hdr_TREADY low until the first edge after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= WAIT_HDR;
            ready_en_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ready_en_r <= 1'b1;
        end
    end

    // Next-state logic: a header with TLAST set is dropped without leaving WAIT_HDR.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            WAIT_HDR: begin
                if (hdr_fire_s && !bus.hdr_TLAST) state_nxt_s = PASS;
                else                              state_nxt_s = WAIT_HDR;
            end
            PASS: begin
                if (pass_fire_s && bus.hdr_TLAST) state_nxt_s = WAIT_HDR;
                else                              state_nxt_s = PASS;
            end
            default: state_nxt_s = WAIT_HDR;
        endcase
    end

    // Output decode: ready and accept strobes depend only on registers and hdr_TVALID.
    always_comb begin
        hdr_ready_s     = 1'b0;
        hdr_fire_s      = 1'b0;
        skid_in_valid_s = 1'b0;
        pass_fire_s     = 1'b0;
        case (state_r)
            WAIT_HDR: begin
                hdr_ready_s = ready_en_r;
                hdr_fire_s  = ready_en_r & bus.hdr_TVALID;
            end
            PASS: begin
                hdr_ready_s     = ready_en_r & skid_in_ready_s;
                skid_in_valid_s = ready_en_r & bus.hdr_TVALID;
                pass_fire_s     = skid_in_valid_s & skid_in_ready_s;
            end
            default: hdr_ready_s = 1'b0;
        endcase
    end

    assign bus.hdr_TREADY = hdr_ready_s;

    // Sidechannel latch, updated only by a header that opens a packet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dest_r <= '0;
            id_r   <= '0;
            user_r <= '0;
        end else if (hdr_fire_s && !bus.hdr_TLAST) begin
            dest_r <= bus.hdr_TDATA[DEST_LSB +: DEST_WIDTH];
            id_r   <= bus.hdr_TDATA[ID_LSB +: ID_WIDTH];
            user_r <= bus.hdr_TDATA[USER_LSB +: USER_WIDTH];
        end
    end

    axis_skid_reg #(
        .WIDTH(PAY_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  ({bus.hdr_TDATA, bus.hdr_TKEEP, bus.hdr_TLAST, dest_r, id_r, user_r}),
        .in_valid (skid_in_valid_s),
        .in_ready (skid_in_ready_s),
        .out_data (skid_out_s),
        .out_valid(bus.sides_TVALID),
        .out_ready(bus.sides_TREADY)
    );

    assign {bus.sides_TDATA, bus.sides_TKEEP, bus.sides_TLAST,
            bus.sides_TDEST, bus.sides_TID, bus.sides_TUSER} = skid_out_s;

`ifdef AXIS_DEHEADERIZER_CHECK_EN
    localparam int LAST_BIT = hdr_last_bit(USER_WIDTH, ID_WIDTH, DEST_WIDTH);
    localparam int PAD_LSB  = hdr_pad_lsb(USER_WIDTH, ID_WIDTH, DEST_WIDTH);

    logic hdr_last_r;
    logic first_r;
    logic err_r;

    // Sticky error: dirty pad, discarded header, or hdr_last disagreeing with first flit TLAST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_last_r <= 1'b0;
            first_r    <= 1'b0;
            err_r      <= 1'b0;
        end else if (hdr_fire_s) begin
            hdr_last_r <= bus.hdr_TDATA[LAST_BIT];
            first_r    <= ~bus.hdr_TLAST;
            if (((bus.hdr_TDATA >> PAD_LSB) != '0) || bus.hdr_TLAST) err_r <= 1'b1;
        end else if (pass_fire_s) begin
            first_r <= 1'b0;
            if (first_r && (bus.hdr_TLAST != hdr_last_r)) err_r <= 1'b1;
        end
    end

    assign err = err_r;
`endif
endmodule
